// File: rtl/qdec_pkg.sv
// Shared types and helpers for the scanned quadrature decoder (qdec_scan_sched).
// Per-channel state record, step-delta encodings and channel-index width.
package qdec_pkg;

   // Stored count field is sized for the widest supported CW; only CW LSBs are live.
   localparam int QDEC_CW_MAX = 32;

   function automatic int qdec_chw(input int nch);
      return (nch > 2) ? $clog2(nch) : 1;
   endfunction

   typedef struct packed {
      logic                   prev_a;
      logic                   prev_b;
      logic                   prev_z;
      logic                   dir;
      logic                   err;
      logic                   homed;
      logic [QDEC_CW_MAX-1:0] count;
   } qdec_state_t;

   localparam logic signed [2:0] DELTA_M2 = -3'sd2;
   localparam logic signed [2:0] DELTA_M1 = -3'sd1;
   localparam logic signed [2:0] DELTA_0  =  3'sd0;
   localparam logic signed [2:0] DELTA_P1 =  3'sd1;
   localparam logic signed [2:0] DELTA_P2 =  3'sd2;

endpackage

// File: rtl/qdec_scan_sched_step.sv
// Combinational quadrature step evaluator shared by all scanned channels.
// QDEC_SKIP_COMP_EN: when defined, a skip moves the count by 2 along the stored direction.
module qdec_step
   import qdec_pkg::*;
(
   input  logic              prev_a,
   input  logic              prev_b,
   input  logic              dir_i,
   input  logic              cur_a,
   input  logic              cur_b,
   output logic signed [2:0] delta,
   output logic              dir_o,
   output logic              skip
);

   always_comb begin
      delta = DELTA_0;
      dir_o = dir_i;
      skip  = 1'b0;
      case ({prev_a ^ cur_a, prev_b ^ cur_b})
         2'b01, 2'b10: begin
            dir_o = cur_b ^ prev_a;
            delta = dir_o ? DELTA_P1 : DELTA_M1;
         end
         2'b11: begin
            skip = 1'b1;
`ifdef QDEC_SKIP_COMP_EN
            delta = dir_i ? DELTA_P2 : DELTA_M2;
`else
            delta = DELTA_0;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/qdec_scan_sched.sv
// Round-robin scanned quadrature decoder: one channel read-modify-written per clock.
// Optional QDEC_SKIP_COMP_EN (in qdec_step) compensates dual-phase skips by +/-2.
module qdec_scan_sched
   import qdec_pkg::*;
#(
   parameter  int NCH         = 4,
   parameter  int CW          = 16,
   parameter  int SYNC_STAGES = 2,
   localparam int CHW         = qdec_chw(NCH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NCH-1:0]  a,
   input  logic [NCH-1:0]  b,
   input  logic [NCH-1:0]  z,
   input  logic [NCH-1:0]  z_en,
   input  logic            clr_req,
   input  logic [CHW-1:0]  clr_ch,
   input  logic            rd_req,
   input  logic [CHW-1:0]  rd_ch,
   output logic            rd_valid,
   output logic [CW-1:0]   rd_data,
   output logic            rd_err,
   output logic [NCH-1:0]  homed
);

   localparam logic [CHW:0]   NCH_W  = (CHW+1)'(NCH);
   localparam logic [CHW-1:0] LAST_CH = CHW'(NCH-1);

   logic [3*NCH-1:0] sync_q [SYNC_STAGES];
   logic [3*NCH-1:0] sync_d [SYNC_STAGES];
   logic [NCH-1:0]   a_s, b_s, z_s;

   logic [CHW-1:0]   scan_q, scan_d;
   qdec_state_t      st_q [NCH];
   qdec_state_t      st_d [NCH];
   qdec_state_t      st_w [NCH];
   qdec_state_t      cur, nxt;

   logic             rd_valid_q, rd_valid_d;
   logic [CW-1:0]    rd_data_q, rd_data_d;
   logic             rd_err_q, rd_err_d;

   logic signed [2:0] step_delta;
   logic             step_dir, step_skip;
   logic             cur_a_s, cur_b_s, cur_z_s;
   logic [CW-1:0]    cnt_new;
   logic             clr_ok, rd_ok;

   always_comb begin
      sync_d[0] = {z, b, a};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   assign a_s = sync_q[SYNC_STAGES-1][NCH-1:0];
   assign b_s = sync_q[SYNC_STAGES-1][2*NCH-1:NCH];
   assign z_s = sync_q[SYNC_STAGES-1][3*NCH-1:2*NCH];

   assign scan_d  = (scan_q == LAST_CH) ? '0 : scan_q + 1'b1;
   assign cur     = st_q[scan_q];
   assign cur_a_s = a_s[scan_q];
   assign cur_b_s = b_s[scan_q];
   assign cur_z_s = z_s[scan_q];
   assign clr_ok  = clr_req && ({1'b0, clr_ch} < NCH_W);
   assign rd_ok   = {1'b0, rd_ch} < NCH_W;

   qdec_step u_step (
      .prev_a (cur.prev_a),
      .prev_b (cur.prev_b),
      .dir_i  (cur.dir),
      .cur_a  (cur_a_s),
      .cur_b  (cur_b_s),
      .delta  (step_delta),
      .dir_o  (step_dir),
      .skip   (step_skip)
   );

   always_comb begin
      nxt        = cur;
      nxt.prev_a = cur_a_s;
      nxt.prev_b = cur_b_s;
      nxt.prev_z = cur_z_s;
      nxt.dir    = step_dir;
      cnt_new    = cur.count[CW-1:0] + CW'(step_delta);
      nxt.count  = QDEC_CW_MAX'(cnt_new);
      if (step_skip) nxt.err = 1'b1;
      if (cur_z_s && !cur.prev_z && z_en[scan_q]) begin
         nxt.count = '0;
         nxt.homed = 1'b1;
      end

      st_w         = st_q;
      st_w[scan_q] = nxt;
      // Clear beats the scan write but keeps the freshly sampled phases.
      if (clr_ok) begin
         st_w[clr_ch].count = '0;
         st_w[clr_ch].err   = 1'b0;
         st_w[clr_ch].homed = 1'b0;
      end

      st_d = st_w;
      if (rd_req && rd_ok && !(rd_ch == scan_q && step_skip)) st_d[rd_ch].err = 1'b0;

      rd_valid_d = rd_req;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;
      if (rd_req) begin
         rd_data_d = '0;
         rd_err_d  = 1'b0;
         if (rd_ok) begin
            rd_data_d = st_w[rd_ch].count[CW-1:0];
            rd_err_d  = st_w[rd_ch].err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         for (int i = 0; i < NCH; i++) st_q[i] <= '0;
         scan_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
         for (int i = 0; i < NCH; i++) st_q[i] <= st_d[i];
         scan_q     <= scan_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) homed[i] = st_q[i].homed;
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_qdec_scan_sched.sv
// Directed self-checking bench for qdec_scan_sched (NCH=4, CW=16 plus a CW=8 twin).
module tb_qdec_scan_sched;

   localparam int NCH = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] a = '0, b = '0, z = '0, z_en = '0;
   logic           clr_req = 1'b0, rd_req = 1'b0;
   logic [1:0]     clr_ch = '0, rd_ch = '0;
   logic           rd_valid, rd_err, rd_valid8, rd_err8;
   logic [15:0]    rd_data;
   logic [7:0]     rd_data8;
   logic [NCH-1:0] homed, homed8;

   int total = 0;
   int bad = 0;
   int ph [NCH];
   int scan_m;

   qdec_scan_sched #(.NCH(NCH), .CW(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z), .z_en(z_en),
      .clr_req(clr_req), .clr_ch(clr_ch), .rd_req(rd_req), .rd_ch(rd_ch),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .homed(homed)
   );

   qdec_scan_sched #(.NCH(NCH), .CW(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z), .z_en(z_en),
      .clr_req(clr_req), .clr_ch(clr_ch), .rd_req(rd_req), .rd_ch(rd_ch),
      .rd_valid(rd_valid8), .rd_data(rd_data8), .rd_err(rd_err8), .homed(homed8)
   );

   always #5 clk = ~clk;

   // Channel the scanner will visit at the next rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) scan_m <= 0;
      else        scan_m <= (scan_m + 1) % NCH;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ph(input int ch);
      a[ch] = (ph[ch] == 2 || ph[ch] == 3);
      b[ch] = (ph[ch] == 1 || ph[ch] == 2);
   endtask

   task automatic step(input int ch, input bit fwd);
      ph[ch] = fwd ? (ph[ch] + 1) % 4 : (ph[ch] + 3) % 4;
      @(negedge clk);
      drive_ph(ch);
      repeat (8) @(posedge clk);
   endtask

   task automatic rd_chk(input int ch, input int exp_data, input int exp_err, input string tag);
      @(negedge clk);
      rd_req = 1'b1;
      rd_ch  = 2'(ch);
      @(posedge clk);
      #1;
      chk({tag, " rd_valid"}, 32'(rd_valid), 1);
      chk({tag, " rd_data"}, 32'(rd_data), exp_data);
      chk({tag, " rd_err"}, 32'(rd_err), exp_err);
      rd_req = 1'b0;
   endtask

   initial begin
      int hit;
      for (int i = 0; i < NCH; i++) ph[i] = 0;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      chk("reset rd_valid", 32'(rd_valid), 0);
      chk("reset rd_data", 32'(rd_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      for (int ch = 0; ch < NCH; ch++) rd_chk(ch, 0, 0, $sformatf("idle ch%0d", ch));
      chk("idle homed", 32'(homed), 0);
      chk("idle homed8", 32'(homed8), 0);

      // ch1 forward then reverse Gray sequence
      for (int i = 0; i < 4; i++) step(1, 1'b1);
      rd_chk(1, 4, 0, "ch1 fwd4");
      for (int i = 0; i < 4; i++) step(1, 1'b0);
      rd_chk(1, 0, 0, "ch1 rev4");
      rd_chk(0, 0, 0, "ch0 quiet");
      rd_chk(2, 0, 0, "ch2 quiet");
      rd_chk(3, 0, 0, "ch3 quiet");

      // ch2 wrap boundaries (16-bit and 8-bit twin)
      step(2, 1'b0);
      rd_chk(2, 'hFFFF, 0, "ch2 underflow");
      chk("w8 underflow data", 32'(rd_data8), 'hFF);
      step(2, 1'b1);
      for (int i = 0; i < 127; i++) step(2, 1'b1);
      rd_chk(2, 'h007F, 0, "ch2 at 7f");
      chk("w8 at 7f data", 32'(rd_data8), 'h7F);
      step(2, 1'b1);
      rd_chk(2, 'h0080, 0, "ch2 to 80");
      chk("w8 signed wrap data", 32'(rd_data8), 'h80);
      chk("w8 rd_valid", 32'(rd_valid8), 1);
      chk("w8 rd_err", 32'(rd_err8), 0);

      // ch0 forward step then dual-phase skip
      step(0, 1'b1);
      rd_chk(0, 1, 0, "ch0 fwd1");
      ph[0] = 3;
      @(negedge clk);
      drive_ph(0);
      repeat (8) @(posedge clk);
`ifdef QDEC_SKIP_COMP_EN
      rd_chk(0, 3, 1, "ch0 skip");
      rd_chk(0, 3, 0, "ch0 reread");
`else
      rd_chk(0, 1, 1, "ch0 skip");
      rd_chk(0, 1, 0, "ch0 reread");
`endif

      // ch3 index: disabled, then enabled
      for (int i = 0; i < 25; i++) step(3, 1'b1);
      rd_chk(3, 25, 0, "ch3 at 25");
      @(posedge clk);
      #1;
      chk("hold rd_valid", 32'(rd_valid), 0);
      chk("hold rd_data", 32'(rd_data), 25);
      @(negedge clk);
      z[3] = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      z[3] = 1'b0;
      repeat (8) @(posedge clk);
      rd_chk(3, 25, 0, "ch3 z masked");
      chk("ch3 z masked homed", 32'(homed), 0);
      @(negedge clk);
      z_en[3] = 1'b1;
      z[3] = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      z[3] = 1'b0;
      repeat (8) @(posedge clk);
      z_en[3] = 1'b0;
      rd_chk(3, 0, 0, "ch3 z zero");
      chk("ch3 homed", 32'(homed), 'b1000);

      // ch1 clear and read on the edge that carries a forward step
      @(negedge clk);
      ph[1] = 1;
      drive_ph(1);
      hit = 0;
      for (int k = 1; k <= 8; k++) begin
         if (k >= 3 && scan_m == 1) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      chk("clr align", 32'(hit), 1);
      clr_req = 1'b1;
      clr_ch  = 2'd1;
      rd_req  = 1'b1;
      rd_ch   = 2'd1;
      @(posedge clk);
      #1;
      chk("clr+rd rd_valid", 32'(rd_valid), 1);
      chk("clr+rd rd_data", 32'(rd_data), 0);
      chk("clr+rd rd_err", 32'(rd_err), 0);
      clr_req = 1'b0;
      rd_req  = 1'b0;
      repeat (8) @(posedge clk);
      rd_chk(1, 0, 0, "ch1 after clr");

      // Mid-operation reset
      @(negedge clk);
      a = '0;
      b = '0;
      repeat (8) @(posedge clk);
      rd_chk(2, 'h0080, 0, "ch2 pre reset");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst rd_data", 32'(rd_data), 0);
      chk("async rst homed", 32'(homed), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      rd_chk(2, 0, 0, "ch2 post reset");
      rd_chk(3, 0, 0, "ch3 post reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
